// File: rtl/io_trap_ctrl_pkg.sv
// Shared types and constants for the MegaMapper I/O trap sequencer.
// Port groups are the upper address nibble; one trap_map bit per group.
package io_trap_ctrl_pkg;

    localparam int GRP_W           = 4;
    localparam int NUM_GRPS        = 1 << GRP_W;
    localparam int DEF_NMI_CYCLES  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_USER   = 3'd0,
        ST_PEND   = 3'd1,
        ST_NMI    = 3'd2,
        ST_SUPER  = 3'd3,
        ST_UNTRAP = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] port;
        logic [7:0] data;
        logic       dir;
    } trap_rec_t;

    function automatic logic [GRP_W-1:0] port_group(input logic [7:0] a);
        return a[7 -: GRP_W];
    endfunction

endpackage

// File: rtl/io_trap_ctrl_if.sv
// CPU bus, decoder and mapper-facing signals of the I/O trap sequencer.
// master = bus sampler/decoder side, slave = the trap controller.
interface io_trap_ctrl_if;
    import io_trap_ctrl_pkg::*;

    logic                iorq_n;
    logic                m1_n;
    logic [7:0]          addr;
    logic [7:0]          data_in;
    logic                io_direction;
    logic                new_isr;
    logic                last_isr_untrap;
    logic [NUM_GRPS-1:0] trap_map;
    logic                trap_en;
    logic                nmi_n;
    logic                super_mode;
    logic                ignore_next_isr;
    logic [7:0]          trap_port;
    logic [7:0]          trap_data;
    logic                trap_dir;
    logic                trap_busy;

    modport master (
        output iorq_n, m1_n, addr, data_in, io_direction, new_isr, last_isr_untrap,
               trap_map, trap_en,
        input  nmi_n, super_mode, ignore_next_isr, trap_port, trap_data, trap_dir, trap_busy
    );

    modport slave (
        input  iorq_n, m1_n, addr, data_in, io_direction, new_isr, last_isr_untrap,
               trap_map, trap_en,
        output nmi_n, super_mode, ignore_next_isr, trap_port, trap_data, trap_dir, trap_busy
    );

endinterface

// File: rtl/io_trap_ctrl_bus_sync.sv
// Synchroniser for an async bus strobe plus registered change detect.
// Latency: lvl/chg appear STAGES+1 clks after the pin edge; no backpressure.
module io_trap_ctrl_bus_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic chg
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              last_q, last_d;
    logic              chg_q, chg_d;

    always_comb begin
        chain_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        last_d = chain_q[STAGES-1];
        // lvl and chg are registered together so chg marks the cycle lvl takes its new value
        chg_d  = last_q ^ chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
            last_q  <= RST_VAL;
            chg_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            last_q  <= last_d;
            chg_q   <= chg_d;
        end
    end

    assign lvl = last_q;
    assign chg = chg_q;

endmodule

// File: rtl/io_trap_ctrl.sv
// Traps user-mode Z80 IN/OUT cycles via a per-group map, pulses NMI and selects supervisor mode until RETN.
// Latency: NMI starts SYNC_STAGES+2 clks after the trapped IORQ ends; no backpressure (extra I/O while busy is dropped).
module io_trap_ctrl
    import io_trap_ctrl_pkg::*;
#(
    parameter int NMI_CYCLES  = DEF_NMI_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    io_trap_ctrl_if.slave bus
);

    localparam int             CNT_W    = $clog2(NMI_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_CYCLES - 1);

    logic iorq_lvl, iorq_chg, m1_lvl, m1_chg;
    logic io_start, iorq_rise, m1_rise, hit;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            m1_seen_q, m1_seen_d;
    trap_rec_t       trap_q, trap_d;
    logic            nmi_n_q, nmi_n_d;
    logic            super_q, super_d;
    logic            ignore_q, ignore_d;
    logic            busy_q, busy_d;

    io_trap_ctrl_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_iorq_sync (
        .clk (clk),
        .rst (rst),
        .din (bus.iorq_n),
        .lvl (iorq_lvl),
        .chg (iorq_chg)
    );

    io_trap_ctrl_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_m1_sync (
        .clk (clk),
        .rst (rst),
        .din (bus.m1_n),
        .lvl (m1_lvl),
        .chg (m1_chg)
    );

    // IORQ with M1 low is an interrupt acknowledge, never a port access
    assign io_start  = iorq_chg & ~iorq_lvl & m1_lvl;
    assign iorq_rise = iorq_chg & iorq_lvl;
    assign m1_rise   = m1_chg & m1_lvl;
    assign hit       = io_start & bus.trap_en & bus.trap_map[port_group(bus.addr)]
                     & (state_q == ST_USER);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m1_seen_d = m1_seen_q;
        trap_d    = trap_q;
        case (state_q)
            ST_USER: begin
                m1_seen_d = 1'b0;
                if (hit) begin
                    trap_d  = '{port: bus.addr, data: bus.data_in, dir: bus.io_direction};
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (iorq_rise) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_NMI;
                end
            end
            ST_NMI: begin
                if (cnt_q == '0) state_d = ST_SUPER;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_SUPER: begin
                m1_seen_d = 1'b0;
                if (bus.last_isr_untrap) state_d = ST_UNTRAP;
            end
            ST_UNTRAP: begin
                // only an M1 that ends after RETN was reported belongs to the next instruction
                if (m1_rise) m1_seen_d = 1'b1;
                if (bus.new_isr && (m1_rise || m1_seen_q)) state_d = ST_USER;
            end
            default: state_d = ST_USER;
        endcase

        nmi_n_d  = (state_d != ST_NMI);
        super_d  = (state_d == ST_NMI) || (state_d == ST_SUPER) || (state_d == ST_UNTRAP);
        ignore_d = (state_d == ST_NMI);
        busy_d   = (state_d != ST_USER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_USER;
            cnt_q     <= '0;
            m1_seen_q <= 1'b0;
            trap_q    <= '0;
            nmi_n_q   <= 1'b1;
            super_q   <= 1'b0;
            ignore_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m1_seen_q <= m1_seen_d;
            trap_q    <= trap_d;
            nmi_n_q   <= nmi_n_d;
            super_q   <= super_d;
            ignore_q  <= ignore_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.nmi_n           = nmi_n_q;
    assign bus.super_mode      = super_q;
    assign bus.ignore_next_isr = ignore_q;
    assign bus.trap_port       = trap_q.port;
    assign bus.trap_data       = trap_q.data;
    assign bus.trap_dir        = trap_q.dir;
    assign bus.trap_busy       = busy_q;

endmodule

// File: tb/tb_io_trap_ctrl.sv
// Bench for io_trap_ctrl: directed cases then random I/O cycles, scoreboarded on each NMI pulse.
module tb_io_trap_ctrl;
    import io_trap_ctrl_pkg::*;

    localparam int NMI_CYC = 8;
    localparam int SYNC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_trap_ctrl_if bus();

    io_trap_ctrl #(.NMI_CYCLES(NMI_CYC), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    trap_rec_t exp_q[$];
    bit        model_busy;
    trap_rec_t model_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every falling nmi_n must match the oldest predicted trap
    initial begin : monitor
        logic      nmi_prev;
        int        low_cnt;
        bit        tracking;
        trap_rec_t e;
        nmi_prev = 1'b1;
        low_cnt  = 0;
        tracking = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tracking = 1'b0;
                nmi_prev = 1'b1;
            end else begin
                if (nmi_prev && !bus.nmi_n) begin
                    tracking = 1'b1;
                    low_cnt  = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_nmi: port 0x%0h dir %0d, no trap predicted", bus.trap_port, bus.trap_dir);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_port", bus.trap_port, e.port);
                        check("sb_dir", bus.trap_dir, e.dir);
                        if (!e.dir) check("sb_data", bus.trap_data, e.data);
                        check("sb_super_at_nmi", bus.super_mode, 1);
                        check("sb_ignore_at_nmi", bus.ignore_next_isr, 1);
                        check("sb_busy_at_nmi", bus.trap_busy, 1);
                    end
                end
                if (tracking && !bus.nmi_n) low_cnt++;
                if (tracking && !nmi_prev && bus.nmi_n) begin
                    check("nmi_len", low_cnt, NMI_CYC);
                    check("ignore_after_nmi", bus.ignore_next_isr, 0);
                    check("super_after_nmi", bus.super_mode, 1);
                    tracking = 1'b0;
                end
                nmi_prev = bus.nmi_n;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nmi_n"}, bus.nmi_n, 1);
        check({tag, "_super"}, bus.super_mode, 0);
        check({tag, "_ignore"}, bus.ignore_next_isr, 0);
        check({tag, "_port"}, bus.trap_port, 0);
        check({tag, "_data"}, bus.trap_data, 0);
        check({tag, "_dir"}, bus.trap_dir, 0);
        check({tag, "_busy"}, bus.trap_busy, 0);
    endtask

    // A trap fires only for a real port access in user mode on an enabled group
    task automatic io_cycle(input logic [7:0] port, input logic [7:0] data, input logic dir,
                            input bit intack, input bit untrap_too, input int post_wait);
        if (!intack && bus.trap_en && bus.trap_map[port >> 4] && !model_busy) begin
            trap_rec_t r;
            r.port = port;
            r.data = data;
            r.dir  = dir;
            exp_q.push_back(r);
            model_last = r;
            model_busy = 1'b1;
        end
        @(negedge clk);
        bus.addr         = port;
        bus.data_in      = data;
        bus.io_direction = dir;
        bus.m1_n         = intack ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
        bus.iorq_n = 1'b0;
        if (untrap_too) bus.last_isr_untrap = 1'b1;
        repeat (6) @(negedge clk);
        bus.iorq_n          = 1'b1;
        bus.m1_n            = 1'b1;
        bus.last_isr_untrap = 1'b0;
        repeat (post_wait) @(negedge clk);
    endtask

    task automatic check_after_cycle(input string tag);
        check({tag, "_busy"}, bus.trap_busy, model_busy);
        check({tag, "_super"}, bus.super_mode, model_busy);
        check({tag, "_nmi_n"}, bus.nmi_n, 1);
        check({tag, "_ignore"}, bus.ignore_next_isr, 0);
        check({tag, "_port"}, bus.trap_port, model_last.port);
        check({tag, "_dir"}, bus.trap_dir, model_last.dir);
        if (!model_last.dir) check({tag, "_data"}, bus.trap_data, model_last.data);
    endtask

    // RETN reported, then the next instruction's M1; supervisor mode ends one clk after the synced M1 edge
    task automatic do_return(input string tag);
        int k;
        @(negedge clk);
        bus.last_isr_untrap = 1'b1;
        @(negedge clk);
        bus.last_isr_untrap = 1'b0;
        repeat (3) @(negedge clk);
        bus.m1_n = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_hold_super"}, bus.super_mode, 1);
        bus.new_isr = 1'b1;
        bus.m1_n    = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.super_mode && k < 12);
        check({tag, "_latency"}, k, SYNC + 2);
        bus.new_isr = 1'b0;
        model_busy  = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, bus.trap_busy, 0);
        check({tag, "_port_hold"}, bus.trap_port, model_last.port);
    endtask

    initial begin : stimulus
        int         iters;
        logic [7:0] p, d;
        bit         dr, ia, ut;
        bus.iorq_n          = 1'b1;
        bus.m1_n            = 1'b1;
        bus.addr            = '0;
        bus.data_in         = '0;
        bus.io_direction    = 1'b0;
        bus.new_isr         = 1'b0;
        bus.last_isr_untrap = 1'b0;
        bus.trap_map        = '0;
        bus.trap_en         = 1'b0;
        model_busy          = 1'b0;
        model_last          = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // OUT (0x41),0x5A on an enabled group, then a second OUT while supervised
        bus.trap_map = 16'h0010;
        bus.trap_en  = 1'b1;
        io_cycle(8'h41, 8'h5A, 1'b0, 1'b0, 1'b0, 20);
        check_after_cycle("out41");
        io_cycle(8'h42, 8'h99, 1'b0, 1'b0, 1'b0, 20);
        check_after_cycle("out42_in_super");
        do_return("ret1");

        // IN from a disabled group and an int-ack on an enabled port: no trap
        io_cycle(8'h80, 8'h33, 1'b1, 1'b0, 1'b0, 20);
        check_after_cycle("in80");
        io_cycle(8'h41, 8'h77, 1'b0, 1'b1, 1'b0, 20);
        check_after_cycle("intack41");

        // Hit coinciding with a stray RETN report: the trap wins
        io_cycle(8'h43, 8'h11, 1'b0, 1'b0, 1'b1, 20);
        check_after_cycle("hit_untrap");
        do_return("ret2");

        // trap_en dropped mid-sequence does not abort
        io_cycle(8'h4C, 8'hC3, 1'b1, 1'b0, 1'b0, 6);
        bus.trap_en = 1'b0;
        repeat (14) @(negedge clk);
        check_after_cycle("en_drop");
        do_return("ret3");
        bus.trap_en = 1'b1;

        // Reset asserted while NMI is being driven
        io_cycle(8'h4F, 8'h22, 1'b0, 1'b0, 1'b0, 6);
        check("pre_rst_nmi_low", bus.nmi_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_busy = 1'b0;
        model_last = '0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        for (iters = 0; iters < 30; iters++) begin
            if ($urandom_range(0, 3) == 0 || iters == 0) bus.trap_map = 16'($urandom);
            bus.trap_en = ($urandom_range(0, 4) != 0);
            p  = 8'($urandom);
            d  = 8'($urandom);
            dr = 1'($urandom_range(0, 1));
            ia = ($urandom_range(0, 5) == 0);
            ut = ($urandom_range(0, 4) == 0);
            io_cycle(p, d, dr, ia, ut, 20);
            check_after_cycle("rnd");
            if (model_busy) begin
                if ($urandom_range(0, 1) == 1) begin
                    io_cycle(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 20);
                    check_after_cycle("rnd_second");
                end
                do_return("rnd_ret");
            end else if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                bus.last_isr_untrap = 1'b1;
                @(negedge clk);
                bus.last_isr_untrap = 1'b0;
                repeat (3) @(negedge clk);
                check("rnd_stray_untrap_busy", bus.trap_busy, 0);
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
